// File: rtl/prog_loader_pkg.sv
// Shared command bytes and FSM state encoding for the instruction-RAM program loader.
package prog_loader_pkg;

    localparam logic [7:0] CMD_LOAD = 8'hA5;
    localparam logic [7:0] CMD_RUN  = 8'h5A;
    localparam logic [7:0] CMD_HALT = 8'h3C;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
    } state_e;

endpackage

// File: rtl/prog_loader_csum.sv
// 8-bit modulo accumulator for the frame checksum; zero_o looks ahead to the
// running sum with data_i added, so the checksum byte can be judged as it arrives.
module prog_loader_csum (
    input  logic       clk,
    input  logic       clr,
    input  logic       clear_i,
    input  logic       add_i,
    input  logic [7:0] data_i,
    output logic       zero_o
);
    logic [7:0] sum_q;
    logic [7:0] sum_next;

    assign sum_next = sum_q + data_i;
    assign zero_o   = (sum_next == 8'h00);

    always_ff @(posedge clk) begin
        if (clr || clear_i) begin
            sum_q <= 8'h00;
        end else if (add_i) begin
            sum_q <= sum_next;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader and core run controller for the instruction RAM.
// Define PROG_LOADER_CSUM_EN to append and verify a per-frame checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] inst_address,
    output logic [7:0]        inst_data,
    output logic              inst_we,
    output logic              core_clr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                rx_ready_q;
    logic [ADDR_W-1:0]   inst_address_q, inst_address_d;
    logic [7:0]          inst_data_q, inst_data_d;
    logic                inst_we_q, inst_we_d;
    logic                core_clr_q, core_clr_d;
    logic                busy_q;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;

`ifdef PROG_LOADER_CSUM_EN
    logic csum_clear, csum_add, csum_zero;

    prog_loader_csum u_csum (
        .clk     (clk),
        .clr     (clr),
        .clear_i (csum_clear),
        .add_i   (csum_add),
        .data_i  (rx_data),
        .zero_o  (csum_zero)
    );
`endif

    assign accept = rx_valid && rx_ready_q;

    always_comb begin
        // NOTE: every signal gets its default first so no path can infer a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        inst_address_d = inst_address_q;
        inst_data_d    = inst_data_q;
        inst_we_d      = 1'b0;
        core_clr_d     = core_clr_q;
        done_d         = 1'b0;
        err_d          = err_q;
`ifdef PROG_LOADER_CSUM_EN
        csum_clear     = 1'b0;
        csum_add       = 1'b0;
`endif
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    case (rx_data)
                        CMD_LOAD: begin
                            err_d      = 1'b0;
                            core_clr_d = 1'b1;
                            state_d    = ST_ADDR;
`ifdef PROG_LOADER_CSUM_EN
                            csum_clear = 1'b1;
`endif
                        end
                        CMD_RUN:  if (!err_q) core_clr_d = 1'b0;
                        CMD_HALT: core_clr_d = 1'b1;
                        default:  err_d = 1'b1;
                    endcase
                end
                ST_ADDR: begin
                    addr_d  = rx_data[ADDR_W-1:0];
                    state_d = ST_LEN;
                end
                ST_LEN: begin
                    cnt_d   = rx_data;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    inst_we_d      = 1'b1;
                    inst_address_d = addr_q;
                    inst_data_d    = rx_data;
                    addr_d         = addr_q + ADDR_W'(1);
`ifdef PROG_LOADER_CSUM_EN
                    csum_add       = 1'b1;
`endif
                    // cnt_q counts remaining bytes after this one; zero marks the last.
                    if (cnt_q == 8'd0) begin
`ifdef PROG_LOADER_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
`ifdef PROG_LOADER_CSUM_EN
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if (csum_zero) done_d = 1'b1;
                    else           err_d  = 1'b1;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (clr) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            cnt_q          <= 8'd0;
            rx_ready_q     <= 1'b0;
            inst_address_q <= '0;
            inst_data_q    <= 8'd0;
            inst_we_q      <= 1'b0;
            core_clr_q     <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            rx_ready_q     <= 1'b1;
            inst_address_q <= inst_address_d;
            inst_data_q    <= inst_data_d;
            inst_we_q      <= inst_we_d;
            core_clr_q     <= core_clr_d;
            busy_q         <= (state_d != ST_IDLE);
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign inst_address = inst_address_q;
    assign inst_data    = inst_data_q;
    assign inst_we      = inst_we_q;
    assign core_clr     = core_clr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; follows PROG_LOADER_CSUM_EN when defined.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [6:0] inst_address;
    logic [7:0] inst_data;
    logic       inst_we;
    logic       core_clr;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;

    prog_loader #(.ADDR_W(7)) dut (
        .clk          (clk),
        .clr          (clr),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .inst_address (inst_address),
        .inst_data    (inst_data),
        .inst_we      (inst_we),
        .core_clr     (core_clr),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Present one byte for one cycle; outputs are then sampled 1 ns after the edge.
    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle();
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, core_clr, busy, done, err, inst_we} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=010000 (rdy,cclr,busy,done,err,we)",
                     {rx_ready, core_clr, busy, done, err, inst_we});
        end
        checks++;
        if ({inst_address, inst_data} !== 15'h0000) begin
            failures++;
            $display("FAIL reset_addr_data got=%h/%h exp=00/00", inst_address, inst_data);
        end
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if ({rx_ready, core_clr, inst_we, busy} !== 4'b1100) begin
                failures++;
                $display("FAIL idle_after_reset[%0d] got=%b exp=1100 (rdy,cclr,we,busy)",
                         i, {rx_ready, core_clr, inst_we, busy});
            end
        end
    endtask

    // One LOAD frame at base with four payload bytes, optional checksum csum.
    task automatic load_frame(input string name, input logic [7:0] base,
                              input logic [7:0] p0, input logic [7:0] p1,
                              input logic [7:0] p2, input logic [7:0] p3,
                              input logic [7:0] csum);
        logic [7:0] pay [4];
        logic       exp_done;
        pay[0] = p0; pay[1] = p1; pay[2] = p2; pay[3] = p3;
        drive(8'hA5);
        checks++;
        if ({core_clr, busy, inst_we, err} !== 4'b1100) begin
            failures++;
            $display("FAIL %s_load_cmd got=%b exp=1100 (cclr,busy,we,err)",
                     name, {core_clr, busy, inst_we, err});
        end
        drive(base);
        drive(8'h03);
        for (int i = 0; i < 4; i++) begin
            drive(pay[i]);
            checks++;
            if ({inst_we, inst_address, inst_data} !== {1'b1, 7'(base + 8'(i)), pay[i]}) begin
                failures++;
                $display("FAIL %s_write[%0d] got we=%b a=%h d=%h exp we=1 a=%h d=%h", name, i,
                         inst_we, inst_address, inst_data, 7'(base + 8'(i)), pay[i]);
            end
`ifdef PROG_LOADER_CSUM_EN
            exp_done = 1'b0;
`else
            exp_done = (i == 3);
`endif
            checks++;
            if ({done, busy} !== {exp_done, ~exp_done}) begin
                failures++;
                $display("FAIL %s_done_busy[%0d] got=%b exp=%b", name, i,
                         {done, busy}, {exp_done, ~exp_done});
            end
        end
`ifdef PROG_LOADER_CSUM_EN
        drive(csum);
        checks++;
        if ({inst_we, done, busy, err} !== 4'b0100) begin
            failures++;
            $display("FAIL %s_csum_end got=%b exp=0100 (we,done,busy,err)",
                     name, {inst_we, done, busy, err});
        end
`else
        if (csum === 8'hxx) $display("unexpected");
`endif
        idle();
        checks++;
        if ({done, err, core_clr, inst_we} !== 4'b0010) begin
            failures++;
            $display("FAIL %s_after_frame got=%b exp=0010 (done,err,cclr,we)",
                     name, {done, err, core_clr, inst_we});
        end
    endtask

    task automatic test_load_run();
        load_frame("load", 8'h10, 8'h11, 8'h22, 8'h33, 8'h44, 8'h56);
        drive(8'h5A);
        checks++;
        if ({core_clr, busy, inst_we} !== 3'b000) begin
            failures++;
            $display("FAIL run_release got=%b exp=000 (cclr,busy,we)", {core_clr, busy, inst_we});
        end
    endtask

    task automatic test_wrap();
        load_frame("wrap", 8'h7E, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hF2);
    endtask

    task automatic test_unknown_halt();
        drive(8'h5A);
        checks++;
        if (core_clr !== 1'b0) begin
            failures++;
            $display("FAIL run_again got=%b exp=0", core_clr);
        end
        drive(8'h77);
        checks++;
        if ({err, inst_we, core_clr, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL unknown_cmd got=%b exp=1000 (err,we,cclr,busy)",
                     {err, inst_we, core_clr, busy});
        end
        drive(8'h3C);
        checks++;
        if ({core_clr, err} !== 2'b11) begin
            failures++;
            $display("FAIL halt got=%b exp=11 (cclr,err)", {core_clr, err});
        end
        drive(8'h5A);
        checks++;
        if ({core_clr, err} !== 2'b11) begin
            failures++;
            $display("FAIL run_with_err got=%b exp=11 (cclr,err)", {core_clr, err});
        end
    endtask

`ifdef PROG_LOADER_CSUM_EN
    task automatic test_bad_csum();
        drive(8'hA5);
        checks++;
        if ({err, busy} !== 2'b01) begin
            failures++;
            $display("FAIL bad_load_cmd got=%b exp=01 (err,busy)", {err, busy});
        end
        drive(8'h00);
        drive(8'h00);
        drive(8'h01);
        checks++;
        if ({inst_we, inst_address, inst_data} !== {1'b1, 7'h00, 8'h01}) begin
            failures++;
            $display("FAIL bad_write got we=%b a=%h d=%h exp we=1 a=00 d=01",
                     inst_we, inst_address, inst_data);
        end
        drive(8'h00);
        checks++;
        if ({err, done, busy, inst_we} !== 4'b1000) begin
            failures++;
            $display("FAIL bad_csum got=%b exp=1000 (err,done,busy,we)", {err, done, busy, inst_we});
        end
        drive(8'h5A);
        checks++;
        if ({core_clr, err} !== 2'b11) begin
            failures++;
            $display("FAIL bad_run_ignored got=%b exp=11 (cclr,err)", {core_clr, err});
        end
        drive(8'hA5);
        checks++;
        if ({err, busy} !== 2'b01) begin
            failures++;
            $display("FAIL bad_reload_clears got=%b exp=01 (err,busy)", {err, busy});
        end
        drive(8'h00);
        drive(8'h00);
        drive(8'h00);
        drive(8'h00);
        checks++;
        if ({done, err, busy} !== 3'b100) begin
            failures++;
            $display("FAIL good_after_bad got=%b exp=100 (done,err,busy)", {done, err, busy});
        end
    endtask
`endif

    task automatic test_clr_mid_data();
        drive(8'hA5);
        drive(8'h20);
        drive(8'h05);
        drive(8'h01);
        checks++;
        if ({inst_we, inst_address, inst_data} !== {1'b1, 7'h20, 8'h01}) begin
            failures++;
            $display("FAIL clr_pre_write got we=%b a=%h d=%h exp we=1 a=20 d=01",
                     inst_we, inst_address, inst_data);
        end
        rx_data  = 8'h02;
        rx_valid = 1'b1;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({rx_ready, core_clr, busy, done, err, inst_we} !== 6'b010000) begin
            failures++;
            $display("FAIL clr_flags got=%b exp=010000 (rdy,cclr,busy,done,err,we)",
                     {rx_ready, core_clr, busy, done, err, inst_we});
        end
        checks++;
        if ({inst_address, inst_data} !== 15'h0000) begin
            failures++;
            $display("FAIL clr_addr_data got=%h/%h exp=00/00", inst_address, inst_data);
        end
        clr      = 1'b0;
        rx_valid = 1'b0;
        idle();
        checks++;
        if ({rx_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL clr_recover got=%b exp=10 (rdy,busy)", {rx_ready, busy});
        end
        drive(8'h5A);
        checks++;
        if ({core_clr, inst_we, busy} !== 3'b000) begin
            failures++;
            $display("FAIL clr_back_in_idle got=%b exp=000 (cclr,we,busy)", {core_clr, inst_we, busy});
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_wrap();
        test_unknown_halt();
`ifdef PROG_LOADER_CSUM_EN
        test_bad_csum();
`endif
        test_clr_mid_data();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
